gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Parametrised next-generation GPIO peripheral behind a simple write_en/read_en register port.
- Adds the following over a plain output register:
  - per-bit direction control;
  - a synchronised input path;
  - atomic set/clear/toggle of output bits;
  - per-bit rising-edge interrupts with write-1-to-clear status and a single level interrupt output.
- Sits between the CPU bus glue and the pads.

Parameters:
- WIDTH, 32, number of GPIO bits and register data width (1..32).
- SYNC_STAGES, 2, flops in the input synchroniser chain (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- addr  input  3  register word address
- write_en  input  1  write strobe, one write per cycle it is high
- read_en  input  1  read strobe
- wdata  input  WIDTH  write data
- rdata  output  WIDTH  registered read data
- gpio_in  input  WIDTH  asynchronous pad inputs
- gpio_out  output  WIDTH  output data to pads
- gpio_oe  output  WIDTH  output enable per bit (1 = drive)
- irq  output  1  level interrupt, active high

Behaviour:
- Reset (asynchronous on resetn low, held until release): all registers, synchroniser flops, edge-history flops, rdata, gpio_out, gpio_oe and irq = 0.
- Register map (addr):
  - 0 OUT: R/W.
  - 1 DIR: R/W, 1 = output.
  - 2 IN: R/O, synchronised pins; writes ignored.
  - 3 SET: W/O, OUT |= wdata.
  - 4 CLR: W/O, OUT &= ~wdata.
  - 5 TOG: W/O, OUT ^= wdata.
  - 6 IE: R/W.
  - 7 IS: R/W1C.
  - Reads of 3/4/5 return 0.
- Writes: take effect at the rising edge where write_en = 1. The new value is visible on gpio_out/gpio_oe from that edge (0-cycle output latency after the edge).
- Reads: rdata loads the addressed register at the rising edge where read_en = 1, so it is valid the following cycle. rdata holds its last value while read_en = 0.
- Simultaneous read and write to the same address: rdata gets the pre-write value.
- gpio_out = OUT regardless of DIR; gpio_oe = DIR. Pad tristating is done outside the block.
- Input path: gpio_in passes through SYNC_STAGES flops. IN = last stage. A pin change is visible in IN after SYNC_STAGES edges.
- Edge detect:
  - prev register holds IN delayed one cycle.
  - rise[i] = IN[i] & ~prev[i] & ~DIR[i]; output-mode bits never raise status.
  - IS[i] sets on the edge following rise[i]. This is SYNC_STAGES+1 edges after the pin change.
  - A pin high out of reset counts as a rising edge, because prev resets to 0.
- IS write-1-to-clear: writing 1 clears the bit; writing 0 leaves it unchanged.
- Same-cycle set and clear of an IS bit: set wins and the bit stays 1.
- irq = |(IS & IE), driven from registers with no combinational path from inputs. irq deasserts the cycle after the clearing write, or after IE is cleared.
- Status bits are sticky: repeated edges while a bit is set have no extra effect.
- Width rule: only bits [WIDTH-1:0] exist. Upper wdata bits are not present.
- Reset mid-operation: all state is lost immediately. The first cycle after release behaves as after power-up.

Test Plan:
- Reset then write OUT=0xDEADBEEF, DIR=0xFFFFFFFF -> gpio_out=0xDEADBEEF, gpio_oe=0xFFFFFFFF after the write edge; read addr0 -> rdata=0xDEADBEEF one cycle after read_en.
- From OUT=0xDEADBEEF: SET 0x00000010, then CLR 0x0000000F, then TOG 0xFFFF0000 -> OUT 0xDEADBEFF, then 0xDEADBEF0, then 0x2152BEF0; reads of addr 3/4/5 -> 0.
- DIR=0, IE=0x1; gpio_in[0] 0->1 -> IN[0]=1 after 2 edges, IS=0x1 and irq=1 after 3 edges; write IS=0x1 -> irq=0 next cycle; write IS=0x0 while IS=0x1 -> no change.
- DIR[3]=1, gpio_in[3] toggles -> IS[3] stays 0. With IE=0 and an edge on bit 5 -> IS[5]=1 and irq=0; then set IE=0x20 -> irq=1.
- Edge arriving in the same cycle as a W1C of that bit -> IS bit remains 1.
- Assert resetn low mid-write with IS=0xFF -> all outputs 0 immediately; after release, reads of all addresses return 0 with gpio_in held low.

Source files
------------

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: output/direction registers, atomic set/clear/toggle, synchronised inputs,
// and per-bit rising-edge interrupt status with a single level interrupt.
module gpio_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       addr,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] AddrOut = 3'd0;
    localparam logic [2:0] AddrDir = 3'd1;
    localparam logic [2:0] AddrIn  = 3'd2;
    localparam logic [2:0] AddrSet = 3'd3;
    localparam logic [2:0] AddrClr = 3'd4;
    localparam logic [2:0] AddrTog = 3'd5;
    localparam logic [2:0] AddrIe  = 3'd6;
    localparam logic [2:0] AddrIs  = 3'd7;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] is_q, is_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] rise;

    assign in_val = sync_q[SYNC_STAGES-1];
    // Output-mode bits never raise status.
    assign rise   = in_val & ~prev_q & ~dir_q;

    always_comb begin
        sync_d[0] = gpio_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        is_d   = is_q;
        prev_d = in_val;
        if (write_en) begin
            unique case (addr)
                AddrOut: out_d = wdata;
                AddrDir: dir_d = wdata;
                AddrSet: out_d = out_q | wdata;
                AddrClr: out_d = out_q & ~wdata;
                AddrTog: out_d = out_q ^ wdata;
                AddrIe:  ie_d  = wdata;
                AddrIs:  is_d  = is_q & ~wdata;
                default: ;
            endcase
        end
        // Applied after the clear so a same-cycle edge keeps the bit set.
        is_d = is_d | rise;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (read_en) begin
            unique case (addr)
                AddrOut: rdata_d = out_q;
                AddrDir: rdata_d = dir_q;
                AddrIn:  rdata_d = in_val;
                AddrIe:  rdata_d = ie_q;
                AddrIs:  rdata_d = is_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            is_q    <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            is_q    <= is_d;
            prev_q  <= prev_d;
            rdata_q <= rdata_d;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a register-access vector table followed by hand-written
// sequences for synchroniser latency, interrupts, W1C races and asynchronous reset.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  addr = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    int total = 0;
    int bad = 0;

    gpio_ctrl #(
        .WIDTH      (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .addr    (addr),
        .write_en(write_en),
        .read_en (read_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr     = a;
        wdata    = d;
        write_en = 1'b1;
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr    = a;
        read_en = 1'b1;
        @(posedge clk);
        #1;
        read_en = 1'b0;
        d       = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rv;

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b0, 3'd1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000};
        vecs[2]  = '{1'b1, 3'd0, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 3'd3, 32'h00000010, 32'hDEADBEFF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 3'd4, 32'h0000000F, 32'hDEADBEF0, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 3'd5, 32'hFFFF0000, 32'h2152BEF0, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 3'd3, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{1'b1, 3'd4, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{1'b1, 3'd5, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{1'b1, 3'd0, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'h2152BEF0};
        vecs[10] = '{1'b1, 3'd1, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 3'd2, 32'h12345678, 32'h2152BEF0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[12] = '{1'b1, 3'd2, 32'h0,        32'h2152BEF0, 32'hFFFFFFFF, 32'h00000000};

        // Reset state
        #12;
        check("reset_out", gpio_out, 32'h0);
        check("reset_oe", gpio_oe, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Register access table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_rd) begin
                do_read(vecs[i].a, rv);
            end else begin
                do_write(vecs[i].a, vecs[i].d);
            end
            check($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
            check($sformatf("vec%0d_oe", i), gpio_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
        end

        // Synchroniser latency and interrupt on bit 0
        do_write(3'd1, 32'h0);
        do_write(3'd6, 32'h1);
        @(negedge clk);
        gpio_in = 32'h1;
        tick();
        check("edge1_irq", {31'h0, irq}, 32'h0);
        tick();
        check("edge2_irq", {31'h0, irq}, 32'h0);
        tick();
        check("edge3_irq", {31'h0, irq}, 32'h1);
        do_read(3'd2, rv);
        check("in_bit0", rv, 32'h1);
        do_read(3'd7, rv);
        check("is_bit0", rv, 32'h1);
        do_write(3'd7, 32'h0);
        check("w0_keeps_irq", {31'h0, irq}, 32'h1);
        do_read(3'd7, rv);
        check("w0_keeps_is", rv, 32'h1);
        do_write(3'd7, 32'h1);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        do_read(3'd7, rv);
        check("w1c_is", rv, 32'h0);

        // Output-mode bit 3 never raises status; bit 5 edge with IE off
        do_write(3'd1, 32'h8);
        do_write(3'd6, 32'h0);
        @(negedge clk);
        gpio_in = 32'h9;
        repeat (4) tick();
        @(negedge clk);
        gpio_in = 32'h1;
        repeat (4) tick();
        @(negedge clk);
        gpio_in = 32'h9;
        repeat (4) tick();
        do_read(3'd7, rv);
        check("dir_out_no_status", rv, 32'h0);
        @(negedge clk);
        gpio_in = 32'h29;
        repeat (4) tick();
        check("ie_off_irq", {31'h0, irq}, 32'h0);
        do_read(3'd7, rv);
        check("ie_off_is", rv, 32'h20);
        do_write(3'd6, 32'h20);
        check("ie_on_irq", {31'h0, irq}, 32'h1);
        do_write(3'd6, 32'h0);
        check("ie_clear_irq", {31'h0, irq}, 32'h0);

        // Edge coincident with a W1C of the same (already set) bit
        @(negedge clk);
        gpio_in = 32'h69;
        repeat (4) tick();
        @(negedge clk);
        gpio_in = 32'h29;
        repeat (4) tick();
        do_read(3'd7, rv);
        check("pre_race_is", rv, 32'h60);
        @(negedge clk);
        gpio_in = 32'h69;
        tick();
        tick();
        do_write(3'd7, 32'h40);
        do_read(3'd7, rv);
        check("race_set_wins", rv, 32'h60);

        // Load IS = 0xFF, then reset mid-write
        do_write(3'd1, 32'h0);
        do_write(3'd6, 32'hFF);
        @(negedge clk);
        gpio_in = 32'h0;
        repeat (4) tick();
        @(negedge clk);
        gpio_in = 32'hFF;
        repeat (4) tick();
        do_read(3'd7, rv);
        check("is_ff", rv, 32'hFF);
        check("irq_before_reset", {31'h0, irq}, 32'h1);
        @(negedge clk);
        addr     = 3'd0;
        wdata    = 32'hA5A5A5A5;
        write_en = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_out", gpio_out, 32'h0);
        check("midrst_oe", gpio_oe, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        write_en = 1'b0;
        gpio_in  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int a = 0; a < 8; a++) begin
            do_read(a[2:0], rv);
            check($sformatf("post_rst_rd%0d", a), rv, 32'h0);
        end
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
